// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for the two-port RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the
// requester/RAM model's view.
interface ram_arbiter_if;
  logic        cpu_req;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;

  logic        vid_req;
  logic        vid_rw;
  logic [15:0] vid_addr;
  logic [15:0] vid_wdata;
  logic        vid_ack;
  logic [15:0] vid_rdata;

  logic [15:0] bus_RAM_ADDRESS;
  logic [15:0] bus_RAM_DATA_OUT;
  logic        wire_RW;
  logic [15:0] bus_RAM_DATA_IN;

  logic        grant;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  vid_req, vid_rw, vid_addr, vid_wdata,
    output vid_ack, vid_rdata,
    output bus_RAM_ADDRESS, bus_RAM_DATA_OUT, wire_RW,
    input  bus_RAM_DATA_IN,
    output grant, busy
  );

  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output vid_req, vid_rw, vid_addr, vid_wdata,
    input  vid_ack, vid_rdata,
    input  bus_RAM_ADDRESS, bus_RAM_DATA_OUT, wire_RW,
    output bus_RAM_DATA_IN,
    input  grant, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the CPU
// (requester 0) and the video/debug port (requester 1). One access at a
// time: IDLE -> ACCESS (RAM_LATENCY cycles) -> DONE (ack pulse) -> IDLE.
module ram_arbiter #(
  parameter int RAM_LATENCY = 1
) (
  input logic          clock,
  input logic          reset,
  ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] LAST = 3'(RAM_LATENCY - 1);

  state_t           state;
  logic [2:0]       cnt;
  logic             owner;      // last/current winner, 0 = CPU
  logic [15:0]      lat_addr;
  logic [15:0]      lat_wdata;
  logic             rw_q;       // latched rw, only high while in ACCESS
  logic [1:0]       ack_q;
  logic [1:0][15:0] rdata_q;
  logic [1:0]       req;
  logic             pick;

  assign req = {bus.vid_req, bus.cpu_req};

  // Contention goes to whoever did not win last; otherwise the sole requester.
  assign pick = (req == 2'b11) ? ~owner : req[1];

  assign bus.bus_RAM_ADDRESS  = lat_addr;
  assign bus.bus_RAM_DATA_OUT = lat_wdata;
  assign bus.wire_RW          = rw_q;
  assign bus.cpu_ack          = ack_q[0];
  assign bus.vid_ack          = ack_q[1];
  assign bus.cpu_rdata        = rdata_q[0];
  assign bus.vid_rdata        = rdata_q[1];
  assign bus.grant            = owner;
  assign bus.busy             = (state != IDLE);

  // Arbitration FSM; all outputs registered so reset clears them at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      owner     <= 1'b1;   // makes the CPU win the first contention
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
      rw_q      <= 1'b0;
      ack_q     <= 2'b00;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 2'b00;
          if (|req) begin
            owner     <= pick;
            lat_addr  <= pick ? bus.vid_addr  : bus.cpu_addr;
            lat_wdata <= pick ? bus.vid_wdata : bus.cpu_wdata;
            rw_q      <= pick ? bus.vid_rw    : bus.cpu_rw;
            cnt       <= 3'd0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == LAST) begin
            if (!rw_q) rdata_q[owner] <= bus.bus_RAM_DATA_IN;
            rw_q         <= 1'b0;
            ack_q[owner] <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          ack_q <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: `clock` and `reset`.
REQ-002 Parameter RAM_LATENCY, default 1: cycles the RAM needs from address-valid to read-data-valid (1..7).
REQ-003 Port `clock` input 1: system clock (the 50 MHz RAM clock).
REQ-004 Port `reset` input 1: asynchronous, active-low reset.
REQ-005 Port `cpu_req` input 1: CPU access request, held high until `cpu_ack`.
REQ-006 Port `cpu_rw` input 1: CPU access type, 1 = write, 0 = read.
REQ-007 Port `cpu_addr` input 16: CPU word address.
REQ-008 Port `cpu_wdata` input 16: CPU write data.
REQ-009 Port `cpu_ack` output 1: one-cycle completion pulse to the CPU.
REQ-010 Port `cpu_rdata` output 16: CPU read data, valid when `cpu_ack` is high and held until the next CPU read.
REQ-011 Ports `vid_req`, `vid_rw`, `vid_addr`, `vid_wdata`, `vid_ack` and `vid_rdata` SHALL be the video/debug requester ports, with identical widths and semantics to the CPU ports.
REQ-012 Port `bus_RAM_ADDRESS` output 16: RAM address.
REQ-013 Port `bus_RAM_DATA_OUT` output 16: write data to the RAM.
REQ-014 Port `wire_RW` output 1: RAM write enable, 1 = write.
REQ-015 Port `bus_RAM_DATA_IN` input 16: read data from the RAM.
REQ-016 Port `grant` output 1: current or last owner, 0 = CPU, 1 = video.
REQ-017 Port `busy` output 1: high in every state except IDLE.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, ACCESS and DONE.
REQ-019 IDLE, no request: stay in IDLE.
REQ-020 IDLE, one request: grant that requester; latch its addr, rw and wdata into internal registers; go to ACCESS.
REQ-021 IDLE, both requests in the same cycle: grant the requester that was NOT granted last (round-robin); after reset the CPU wins the first contention.
REQ-022 ACCESS SHALL last exactly RAM_LATENCY cycles, timed by a 3-bit counter that is cleared on entry to ACCESS.
REQ-023 During ACCESS, `bus_RAM_ADDRESS` and `bus_RAM_DATA_OUT` SHALL carry the latched values, and `wire_RW` SHALL equal the latched rw.
REQ-024 `wire_RW` SHALL be 0 in IDLE and DONE; a write is asserted only during ACCESS cycles.
REQ-025 On the last ACCESS cycle, a read SHALL capture `bus_RAM_DATA_IN` into the winner's rdata register; the FSM then goes to DONE.
REQ-026 DONE SHALL pulse the winner's ack for exactly one cycle, then go to IDLE; the loser's ack and rdata SHALL be unchanged.
REQ-027 Write access: the ack pulse SHALL occur and rdata SHALL be unchanged.
REQ-028 Latency: request sampled in IDLE at cycle 0 -> ACCESS cycles 1..RAM_LATENCY -> ack at cycle RAM_LATENCY+1 -> IDLE at cycle RAM_LATENCY+2.
REQ-029 Sustained back-to-back requests from one requester SHALL be served every RAM_LATENCY+2 cycles.
REQ-030 A requester SHALL drop req in the cycle after its ack; req still high in IDLE is treated as a new request.
REQ-031 req, addr, rw and wdata changes after the grant SHALL have no effect until the next IDLE.
REQ-032 A req deasserted mid-access SHALL NOT abort the access: it completes and ack is still pulsed.
REQ-033 A losing requester SHALL keep its request pending, with no timeout; it is served next because of the round-robin.
REQ-034 `grant` SHALL update only on entry to ACCESS and hold its value through DONE and IDLE.
REQ-035 Addresses 0x0000 and 0xFFFF SHALL pass through unmodified, with no wrap or offset.

Reset
REQ-036 `reset` low SHALL immediately force: state IDLE; `wire_RW`=0; `bus_RAM_ADDRESS`=0x0000; `bus_RAM_DATA_OUT`=0x0000; both acks 0; both rdata 0x0000; `grant`=1 (so the CPU wins the first contention); `busy`=0; counter 0.
REQ-037 Reset asserted mid-ACCESS SHALL abandon the access, with no ack pulse after reset release.
REQ-038 After `reset` rises, the first request SHALL be accepted on the first clock edge at which it is sampled high.

Verification
REQ-039 Scenario: RAM_LATENCY=1; CPU read of 0x0010, RAM returns 0xBEEF -> `bus_RAM_ADDRESS`=0x0010 in cycle 1, `cpu_ack` high in cycle 2, `cpu_rdata`=0xBEEF, `wire_RW`=0 throughout.
REQ-040 Scenario: video write of 0x1234 to 0xFFFF -> `wire_RW`=1 for exactly RAM_LATENCY cycles with `bus_RAM_ADDRESS`=0xFFFF and `bus_RAM_DATA_OUT`=0x1234; `vid_ack` pulses once; `vid_rdata` is unchanged.
REQ-041 Scenario: CPU and video both request continuously from reset -> grants CPU, video, CPU, video, ...; each ack is spaced RAM_LATENCY+2 cycles.
REQ-042 Scenario: `cpu_req` dropped during ACCESS and `cpu_addr` changed -> the access uses the latched address and `cpu_ack` still pulses.
REQ-043 Scenario: reset pulsed low in the middle of a write's ACCESS -> `wire_RW` falls without waiting for a clock, no ack is pulsed, and all outputs equal their reset values.
REQ-044 Scenario: RAM_LATENCY=3; CPU read -> ack at cycle 4, and `bus_RAM_DATA_IN` is sampled on cycle 3 only.
